// File: rtl/dct_vdd2_ctrl.sv
// Sequencer for the VDD2 DCT domain: row writes into the stage-1 bank, stage-2 settle and output.
// Optional block/stall counters are enabled by defining DCT_CTRL_BLK_CNT_EN.
module dct_vdd2_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             approx_req,
    output logic [7:0]       wr_en_entry [7:0],
    output logic [2:0]       row_idx,
    output logic             stage2_en,
    output logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
`ifdef DCT_CTRL_BLK_CNT_EN
    output logic [CNT_W-1:0] blk_cnt,
    output logic [CNT_W-1:0] stall_cnt,
`endif
    output logic             blk_done
);

    typedef enum logic [1:0] {StIdle, StFill, StSettle, StOutWait} state_e;

    localparam logic [7:0] SettleInit = 8'(SETTLE_CYCLES - 1);

    state_e     state;
    logic [2:0] row_ptr;
    logic [7:0] settle_cnt;
    logic       accept;
    logic       out_hs;

    assign in_ready = (state == StIdle) || (state == StFill);
    assign accept   = in_valid & in_ready;
    assign out_hs   = (state == StOutWait) & out_ready;
    assign row_idx  = row_ptr;
    assign busy     = (state != StIdle);

    // The bank captures data_in on the same edge the beat is accepted.
    always_comb begin
        for (int r = 0; r < 8; r++) begin
            wr_en_entry[r] = (accept && (row_ptr == 3'(r))) ? 8'hFF : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            row_ptr    <= 3'd0;
            settle_cnt <= 8'd0;
            approx_en  <= 1'b0;
            stage2_en  <= 1'b0;
            out_valid  <= 1'b0;
            blk_done   <= 1'b0;
        end else begin
            blk_done <= 1'b0;
            case (state)
                StIdle: begin
                    if (accept) begin
                        approx_en <= approx_req;
                        row_ptr   <= 3'd1;
                        state     <= StFill;
                    end
                end
                StFill: begin
                    if (accept) begin
                        if (row_ptr == 3'd7) begin
                            row_ptr    <= 3'd0;
                            settle_cnt <= SettleInit;
                            stage2_en  <= 1'b1;
                            state      <= StSettle;
                        end else begin
                            row_ptr <= row_ptr + 3'd1;
                        end
                    end
                end
                StSettle: begin
                    if (settle_cnt == 8'd0) begin
                        out_valid <= 1'b1;
                        state     <= StOutWait;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                StOutWait: begin
                    if (out_hs) begin
                        stage2_en <= 1'b0;
                        out_valid <= 1'b0;
                        blk_done  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef DCT_CTRL_BLK_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_hs) begin
                blk_cnt <= blk_cnt + CNT_W'(1);
            end
            // Saturates so a long stall never reads back as a short one.
            if ((state == StOutWait) && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dct_vdd2_ctrl.sv
// Self-checking bench for dct_vdd2_ctrl: randomized row gaps, stalls and approx requests
// checked against a block-level model of the expected row order, phases and counters.
module tb_dct_vdd2_ctrl;

    localparam int unsigned SETTLE = 2;
`ifdef DCT_CTRL_BLK_CNT_EN
    localparam int unsigned TB_CNT_W = 4;
`else
    localparam int unsigned TB_CNT_W = 16;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       approx_req;
    logic [7:0] wr_en_entry [7:0];
    logic [2:0] row_idx;
    logic       stage2_en;
    logic       approx_en;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       blk_done;
`ifdef DCT_CTRL_BLK_CNT_EN
    logic [TB_CNT_W-1:0] blk_cnt;
    logic [TB_CNT_W-1:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_blk = 0;
    int exp_stall = 0;

    dct_vdd2_ctrl #(
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (TB_CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .approx_req (approx_req),
        .wr_en_entry(wr_en_entry),
        .row_idx    (row_idx),
        .stage2_en  (stage2_en),
        .approx_en  (approx_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
`ifdef DCT_CTRL_BLK_CNT_EN
        .blk_cnt    (blk_cnt),
        .stall_cnt  (stall_cnt),
`endif
        .blk_done   (blk_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout observed no finish required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wr_flat();
        logic [63:0] v;
        for (int r = 0; r < 8; r++) v[r*8 +: 8] = wr_en_entry[r];
        return v;
    endfunction

    // Inputs change at edge+1, outputs are sampled at edge+2.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counters();
`ifdef DCT_CTRL_BLK_CNT_EN
        chk("blk_cnt", 64'(blk_cnt), 64'(exp_blk % (1 << TB_CNT_W)));
        chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
`endif
    endtask

    task automatic chk_idle(input string tag, input logic exp_approx);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_stage2_en"}, 64'(stage2_en), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_approx_en"}, 64'(approx_en), 64'(exp_approx));
        chk({tag, "_row_idx"}, 64'(row_idx), 64'd0);
    endtask

    task automatic chk_reset();
        in_valid = 1'b0;
        #1;
        chk_idle("reset", 1'b0);
        chk("reset_blk_done", 64'(blk_done), 64'd0);
        chk("reset_wr", wr_flat(), 64'd0);
        chk_counters();
    endtask

    task automatic send_row(input int k, input logic req, input int max_gap);
        int gap;
        gap = int'($urandom_range(max_gap, 0));
        for (int g = 0; g < gap; g++) begin
            in_valid   = 1'b0;
            approx_req = 1'($urandom_range(1, 0));
            out_ready  = 1'($urandom_range(1, 0));
            #1;
            chk("gap_wr", wr_flat(), 64'd0);
            chk("gap_row_idx", 64'(row_idx), 64'(k));
            chk("gap_out_valid", 64'(out_valid), 64'd0);
            tick();
        end
        in_valid   = 1'b1;
        approx_req = req;
        out_ready  = 1'($urandom_range(1, 0));
        #1;
        chk("beat_in_ready", 64'(in_ready), 64'd1);
        chk("beat_row_idx", 64'(row_idx), 64'(k));
        chk("beat_wr", wr_flat(), 64'hFF << (8 * k));
        chk("beat_stage2_en", 64'(stage2_en), 64'd0);
        tick();
    endtask

    task automatic run_block(input logic appr, input logic toggle, input int max_gap,
                             input int stall);
        logic req;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) req = appr;
            else if (toggle && k >= 3) req = ~appr;
            else req = 1'($urandom_range(1, 0));
            send_row(k, req, max_gap);
            chk("fill_approx_en", 64'(approx_en), 64'(appr));
            chk("fill_busy", 64'(busy), 64'd1);
        end
        for (int s = 0; s < int'(SETTLE); s++) begin
            in_valid  = 1'($urandom_range(1, 0));
            out_ready = 1'($urandom_range(1, 0));
            #1;
            chk("settle_stage2_en", 64'(stage2_en), 64'd1);
            chk("settle_out_valid", 64'(out_valid), 64'd0);
            chk("settle_in_ready", 64'(in_ready), 64'd0);
            chk("settle_wr", wr_flat(), 64'd0);
            tick();
        end
        for (int s = 0; s < stall; s++) begin
            in_valid  = 1'($urandom_range(1, 0));
            out_ready = 1'b0;
            #1;
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_stage2_en", 64'(stage2_en), 64'd1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_wr", wr_flat(), 64'd0);
            chk("stall_approx_en", 64'(approx_en), 64'(appr));
            if (exp_stall < (1 << TB_CNT_W) - 1) exp_stall++;
            tick();
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("hs_out_valid", 64'(out_valid), 64'd1);
        chk("hs_in_ready", 64'(in_ready), 64'd0);
        chk("hs_wr", wr_flat(), 64'd0);
        chk("hs_blk_done", 64'(blk_done), 64'd0);
        tick();
        exp_blk++;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk_idle("post", appr);
        chk("post_blk_done", 64'(blk_done), 64'd1);
        chk("post_wr", wr_flat(), 64'd0);
        chk_counters();
        tick();
        #1;
        chk("done_pulse_end", 64'(blk_done), 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        approx_req = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_reset();

        run_block(1'b1, 1'b0, 0, 0);
        run_block(1'b0, 1'b0, 2, 5);
        run_block(1'b1, 1'b1, 1, 1);
        run_block(1'b0, 1'b0, 0, 0);

        // Reset while filling, after row 4 has been written.
        for (int k = 0; k < 5; k++) send_row(k, 1'b1, 1);
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        exp_blk = 0;
        exp_stall = 0;
        chk_reset();
        run_block(1'b1, 1'b0, 0, 2);

        for (int b = 0; b < 18; b++) begin
            run_block(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                      int'($urandom_range(2, 0)), int'($urandom_range(3, 0)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
